frame_writer: RTL

- Drains the pixel FIFO that the filter stage (sobel/gaussian) fills.
- Counts pixels into IMG_WIDTH x IMG_HEIGHT frames and packs DWIDTH_IN pixels into MEM_DWIDTH words.
- Writes the words sequentially to a frame-buffer memory port using a valid/ready handshake.
- Sits at the consumer end of the filter's output FIFO and is the reader for that FIFO's writer.

---
 rtl/img_pkg.sv | 25 ++
 rtl/pixel_packer.sv | 56 +++++
 rtl/frame_writer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared image-pipeline definitions: default frame geometry and data widths,
// the frame_writer state encoding, and a ceil-divide helper used to size
// word counts and address limits.
// ---------------------------------------------------------------------------
package img_pkg;

    localparam int IMG_WIDTH_DEF  = 720;
    localparam int IMG_HEIGHT_DEF = 540;
    localparam int DWIDTH_IN_DEF  = 8;
    localparam int MEM_DWIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } fw_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
// Packs PPW pixels little-endian into one word (pixel k -> bits
// [k*DWIDTH_IN +: DWIDTH_IN]).
//   clock, reset : rising-edge clock, async active-low reset
//   push, din    : accept one pixel into the current slot
//   clear        : drop the partial word (used once the flush word is taken)
//   word         : completed word while push fills the last slot, otherwise
//                  the partial word with unfilled slots reading as zero
//   word_done    : push is filling slot PPW-1 this cycle
// ---------------------------------------------------------------------------
module pixel_packer #(
    parameter int DWIDTH_IN = 8,
    parameter int PPW       = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     clear,
    input  logic [DWIDTH_IN-1:0]     din,
    output logic [PPW*DWIDTH_IN-1:0] word,
    output logic                     word_done
);

    localparam int SW = (PPW > 1) ? $clog2(PPW) : 1;

    logic [SW-1:0]                   slot;
    logic [PPW-1:0][DWIDTH_IN-1:0]   pack;
    logic [PPW-1:0][DWIDTH_IN-1:0]   merged;

    assign word_done = push & (slot == SW'(PPW - 1));

    // Merge the incoming pixel so the completing pop can register the full
    // word in the same cycle. The pack register is cleared after every word,
    // so a flushed partial word already has zeroed upper slots.
    always_comb begin
        merged = pack;
        if (push) merged[slot] = din;
    end

    assign word = merged;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot <= '0;
            pack <= '0;
        end else if (clear || word_done) begin
            slot <= '0;
            pack <= '0;
        end else if (push) begin
            pack[slot] <= din;
            slot       <= slot + SW'(1);
        end
    end

endmodule

// File: rtl/frame_writer.sv
// ---------------------------------------------------------------------------
// frame_writer
// Drains a first-word-fall-through pixel FIFO, counts pixels into
// IMG_WIDTH x IMG_HEIGHT frames, packs them into MEM_DWIDTH words and writes
// the words to sequential addresses from BASE_ADDR with a valid/ready port.
//   clock, reset          : rising-edge clock, async active-low reset
//   enable                : lets a new frame start (sampled in IDLE/DRAIN)
//   fifo_rd_en            : combinational FIFO pop
//   fifo_dout, fifo_empty : FIFO head data / empty flag
//   mem_wr_en, mem_addr,
//   mem_wdata             : registered write request, held until accepted
//   mem_ready             : memory accepts when mem_wr_en & mem_ready
//   frame_done            : one-cycle pulse after the frame's last word
//   frame_checksum        : (FRAME_WRITER_CHECKSUM_EN only) mod-2^16 sum of
//                           the frame's pixels
// Optional build macro: FRAME_WRITER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module frame_writer
    import img_pkg::*;
#(
    parameter int                    DWIDTH_IN  = DWIDTH_IN_DEF,
    parameter int                    MEM_DWIDTH = MEM_DWIDTH_DEF,
    parameter int                    IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int                    IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int                    ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DWIDTH_IN-1:0]  fifo_dout,
    input  logic                  fifo_empty,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DWIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    output logic                  frame_done
`ifdef FRAME_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]           frame_checksum
`endif
);

    localparam int PPW   = MEM_DWIDTH / DWIDTH_IN;
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        BASE_ADDR + ADDR_WIDTH'(ceil_div(TOTAL, PPW) - 1);

    fw_state_t             state, state_nxt;
    logic [CW-1:0]         pix_cnt;
    logic                  last_pix;
    logic                  stall, pop, accept, flush_now;
    logic                  word_done;
    logic [MEM_DWIDTH-1:0] pack_word;

    assign stall      = mem_wr_en & ~mem_ready;
    assign accept     = mem_wr_en & mem_ready;
    assign pop        = (state == RUN) & ~fifo_empty & ~stall;
    assign fifo_rd_en = pop;
    assign last_pix   = (pix_cnt == CW'(TOTAL - 1));
    // FLUSH never sees a pending word in practice, but honour stall anyway.
    assign flush_now  = (state == FLUSH) & ~stall;

    pixel_packer #(
        .DWIDTH_IN (DWIDTH_IN),
        .PPW       (PPW)
    ) u_packer (
        .clock     (clock),
        .reset     (reset),
        .push      (pop),
        .clear     (flush_now),
        .din       (fifo_dout),
        .word      (pack_word),
        .word_done (word_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (pop && last_pix) state_nxt = word_done ? DRAIN : FLUSH;
            FLUSH:   if (!stall) state_nxt = DRAIN;
            DRAIN:   if (accept) state_nxt = enable ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_wr_en  <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
        end else begin
            frame_done <= (state == DRAIN) & accept;

            if (pop) pix_cnt <= last_pix ? '0 : pix_cnt + CW'(1);

            // A pop never happens while stalled, so a new word only loads
            // into an empty slot or one being accepted this same cycle.
            if (word_done || flush_now) begin
                mem_wr_en <= 1'b1;
                mem_wdata <= pack_word;
            end else if (accept) begin
                mem_wr_en <= 1'b0;
            end

            // The last word of a frame always sits at LAST_ADDR, so its
            // acceptance rewinds to the frame base.
            if (accept)
                mem_addr <= (mem_addr == LAST_ADDR) ? BASE_ADDR : mem_addr + ADDR_WIDTH'(1);
        end
    end

`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [15:0] csum;

    // Restarts on the first pop of a frame, so the previous total stays
    // visible from frame_done until the next frame actually begins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)   csum <= '0;
        else if (pop) csum <= ((pix_cnt == '0) ? 16'd0 : csum) + 16'(fifo_dout);
    end

    assign frame_checksum = csum;
`endif

endmodule
